// File: rtl/w_mem_deserializer.sv
// Packs a valid/ready stream of Q-format words into NU_COUNT-lane rows and writes each row to all w_mem instances.
// Optional feature macro: W_DESER_ZERO_PAD_EN (zero-pad a row cut short by an early in_last instead of discarding it).
module w_mem_deserializer #(
    parameter int NU_COUNT    = 8,
    parameter int Q_SIZE      = 16,
    parameter int W_MEM_DEPTH = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [W_MEM_DEPTH-1:0]       base_addr,
    input  logic [W_MEM_DEPTH-1:0]       row_count,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [Q_SIZE-1:0]            in_data,
    input  logic                         in_last,
    output logic                         w_write_enable,
    output logic [W_MEM_DEPTH-1:0]       w_write_addr,
    output logic [NU_COUNT*Q_SIZE-1:0]   w_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int LANE_W = (NU_COUNT > 1) ? $clog2(NU_COUNT) : 1;
    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(NU_COUNT - 1);
    localparam logic [W_MEM_DEPTH-1:0] ONE_ROW   = W_MEM_DEPTH'(1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                 state;
    logic [LANE_W-1:0]      lane;
    logic [W_MEM_DEPTH-1:0] addr;
    logic [W_MEM_DEPTH-1:0] rows_left;
    logic [Q_SIZE-1:0]      row_buf [NU_COUNT];
    logic                   accept;
    logic                   final_word;

    assign accept       = in_valid && in_ready;
    assign final_word   = (lane == LAST_LANE) && (rows_left == ONE_ROW);
    assign w_write_addr = addr;

    for (genvar g = 0; g < NU_COUNT; g++) begin : g_lane
        assign w_data[g*Q_SIZE +: Q_SIZE] = row_buf[g];
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            lane           <= '0;
            addr           <= '0;
            rows_left      <= '0;
            in_ready       <= 1'b0;
            w_write_enable <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            // NOTE: the row buffer is reset because it drives w_data directly and outputs must read 0 in reset.
            for (int i = 0; i < NU_COUNT; i++) row_buf[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        busy  <= 1'b1;
                        lane  <= '0;
                        if (row_count != '0) begin
                            addr      <= base_addr;
                            rows_left <= row_count;
                            in_ready  <= 1'b1;
                            state     <= FILL;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                FILL: begin
                    if (accept) begin
                        row_buf[lane] <= in_data;
                        lane          <= lane + LANE_W'(1);
                        if (in_last && !final_word) begin
`ifdef W_DESER_ZERO_PAD_EN
                            // Lanes above the one carrying in_last are padded; force this to be the final row.
                            for (int i = 0; i < NU_COUNT; i++)
                                if (i > int'(lane)) row_buf[i] <= '0;
                            rows_left      <= ONE_ROW;
                            in_ready       <= 1'b0;
                            w_write_enable <= 1'b1;
                            state          <= WRITE;
`else
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
`endif
                        end else if (lane == LAST_LANE) begin
                            if (final_word && !in_last) error <= 1'b1;
                            in_ready       <= 1'b0;
                            w_write_enable <= 1'b1;
                            state          <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    w_write_enable <= 1'b0;
                    addr           <= addr + ONE_ROW;
                    rows_left      <= rows_left - ONE_ROW;
                    lane           <= '0;
                    if (rows_left == ONE_ROW) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= FILL;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w_mem_deserializer.sv
// Directed bench for w_mem_deserializer at NU_COUNT=4, Q_SIZE=16, W_MEM_DEPTH=4.
// Expected early-in_last behaviour follows W_DESER_ZERO_PAD_EN when defined.
module tb_w_mem_deserializer;

    localparam int NU = 4;
    localparam int QS = 16;
    localparam int AD = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [AD-1:0]    base_addr;
    logic [AD-1:0]    row_count;
    logic             in_valid;
    logic             in_ready;
    logic [QS-1:0]    in_data;
    logic             in_last;
    logic             w_write_enable;
    logic [AD-1:0]    w_write_addr;
    logic [NU*QS-1:0] w_data;
    logic             busy;
    logic             done;
    logic             error;

    int checks = 0;
    int errors = 0;

    logic [AD-1:0]    wr_addr_q [$];
    logic [NU*QS-1:0] wr_data_q [$];
    int               done_cnt = 0;

    always #5 clk = ~clk;

    w_mem_deserializer #(.NU_COUNT(NU), .Q_SIZE(QS), .W_MEM_DEPTH(AD)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .row_count(row_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .w_write_enable(w_write_enable),
        .w_write_addr(w_write_addr), .w_data(w_data), .busy(busy),
        .done(done), .error(error)
    );

    // Records every write strobe and every cycle done is high.
    always @(negedge clk) begin
        if (w_write_enable) begin
            wr_addr_q.push_back(w_write_addr);
            wr_data_q.push_back(w_data);
        end
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [AD-1:0] b, input logic [AD-1:0] r);
        start = 1'b1; base_addr = b; row_count = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [QS-1:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int w0;
        int d0;
        reset = 1'b0; start = 1'b0; base_addr = '0; row_count = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd0);
        chk("reset_wen", 64'(w_write_enable), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        chk("reset_wdata", w_data, 64'd0);
        chk("reset_waddr", 64'(w_write_addr), 64'd0);

        // Two contiguous rows from address 3.
        w0 = wr_addr_q.size(); d0 = done_cnt;
        do_start(4'd3, 4'd2);
        for (int i = 1; i <= 8; i++) send(QS'(i), i == 8);
        wait_idle();
        chk("t1_nwrites", 64'(wr_addr_q.size() - w0), 64'd2);
        chk("t1_addr0", 64'(wr_addr_q[w0]), 64'd3);
        chk("t1_data0", wr_data_q[w0], 64'h0004_0003_0002_0001);
        chk("t1_addr1", 64'(wr_addr_q[w0+1]), 64'd4);
        chk("t1_data1", wr_data_q[w0+1], 64'h0008_0007_0006_0005);
        chk("t1_done", 64'(done_cnt - d0), 64'd1);
        chk("t1_error", 64'(error), 64'd0);

        // Same load with a bubble after every word.
        w0 = wr_addr_q.size(); d0 = done_cnt;
        do_start(4'd3, 4'd2);
        for (int i = 1; i <= 8; i++) begin
            send(QS'(i), i == 8);
            @(negedge clk);
        end
        wait_idle();
        chk("t2_nwrites", 64'(wr_addr_q.size() - w0), 64'd2);
        chk("t2_data0", wr_data_q[w0], 64'h0004_0003_0002_0001);
        chk("t2_data1", wr_data_q[w0+1], 64'h0008_0007_0006_0005);
        chk("t2_addr1", 64'(wr_addr_q[w0+1]), 64'd4);
        chk("t2_done", 64'(done_cnt - d0), 64'd1);

        // Address wraps from 15 to 0.
        w0 = wr_addr_q.size(); d0 = done_cnt;
        do_start(4'd15, 4'd2);
        for (int i = 1; i <= 8; i++) send(QS'(16'h0010 + i), i == 8);
        wait_idle();
        chk("t3_nwrites", 64'(wr_addr_q.size() - w0), 64'd2);
        chk("t3_addr0", 64'(wr_addr_q[w0]), 64'd15);
        chk("t3_addr1", 64'(wr_addr_q[w0+1]), 64'd0);
        chk("t3_data0", wr_data_q[w0], 64'h0014_0013_0012_0011);
        chk("t3_data1", wr_data_q[w0+1], 64'h0018_0017_0016_0015);
        chk("t3_done", 64'(done_cnt - d0), 64'd1);

        // Early in_last on lane 1 of the only row.
        w0 = wr_addr_q.size(); d0 = done_cnt;
        do_start(4'd6, 4'd1);
        send(16'h00AA, 1'b0);
        send(16'h00BB, 1'b1);
        wait_idle();
`ifdef W_DESER_ZERO_PAD_EN
        chk("t4_nwrites", 64'(wr_addr_q.size() - w0), 64'd1);
        chk("t4_addr", 64'(wr_addr_q[w0]), 64'd6);
        chk("t4_data", wr_data_q[w0], 64'h0000_0000_00BB_00AA);
        chk("t4_error", 64'(error), 64'd0);
`else
        chk("t4_nwrites", 64'(wr_addr_q.size() - w0), 64'd0);
        chk("t4_error", 64'(error), 64'd1);
`endif
        chk("t4_done", 64'(done_cnt - d0), 64'd1);

        // Last word of the last row arrives without in_last.
        w0 = wr_addr_q.size(); d0 = done_cnt;
        do_start(4'd9, 4'd1);
        for (int i = 1; i <= 4; i++) send(QS'(16'h00A0 + i), 1'b0);
        wait_idle();
        chk("t7_nwrites", 64'(wr_addr_q.size() - w0), 64'd1);
        chk("t7_addr", 64'(wr_addr_q[w0]), 64'd9);
        chk("t7_data", wr_data_q[w0], 64'h00A4_00A3_00A2_00A1);
        chk("t7_error", 64'(error), 64'd1);
        chk("t7_done", 64'(done_cnt - d0), 64'd1);

        // Reset in the middle of a row.
        w0 = wr_addr_q.size(); d0 = done_cnt;
        do_start(4'd2, 4'd1);
        send(16'h0101, 1'b0);
        send(16'h0102, 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_busy_async", 64'(busy), 64'd0);
        chk("t5_ready_async", 64'(in_ready), 64'd0);
        chk("t5_error_async", 64'(error), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_nowrite", 64'(wr_addr_q.size() - w0), 64'd0);
        chk("t5_nodone", 64'(done_cnt - d0), 64'd0);
        do_start(4'd5, 4'd1);
        for (int i = 1; i <= 4; i++) send(QS'(16'h0C00 + i), i == 4);
        wait_idle();
        chk("t5_nwrites", 64'(wr_addr_q.size() - w0), 64'd1);
        chk("t5_addr", 64'(wr_addr_q[w0]), 64'd5);
        chk("t5_data", wr_data_q[w0], 64'h0C04_0C03_0C02_0C01);
        chk("t5_error", 64'(error), 64'd0);

        // Zero rows, then a start pulse ignored during FILL.
        w0 = wr_addr_q.size(); d0 = done_cnt;
        do_start(4'd4, 4'd0);
        chk("t6_done_hi", 64'(done), 64'd1);
        chk("t6_busy_hi", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t6_done_lo", 64'(done), 64'd0);
        chk("t6_busy_lo", 64'(busy), 64'd0);
        chk("t6_nowrite", 64'(wr_addr_q.size() - w0), 64'd0);
        d0 = done_cnt;
        do_start(4'd7, 4'd1);
        send(16'h0E01, 1'b0);
        do_start(4'd1, 4'd3);
        for (int i = 2; i <= 4; i++) send(QS'(16'h0E00 + i), i == 4);
        wait_idle();
        chk("t6_nwrites", 64'(wr_addr_q.size() - w0), 64'd1);
        chk("t6_addr", 64'(wr_addr_q[w0]), 64'd7);
        chk("t6_data", wr_data_q[w0], 64'h0E04_0E03_0E02_0E01);
        chk("t6_done", 64'(done_cnt - d0), 64'd1);
        chk("t6_next_addr", 64'(w_write_addr), 64'd8);
        chk("t6_error", 64'(error), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
